// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int MAXOP = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_MAX = OPW'(MAXOP);

    logic           last_grant;
    logic           elig0, elig1;
    logic           grant0, grant1;
    logic [OPW-1:0] sel_op;
    logic           illegal;

    // A slot is free when empty or being drained this cycle, so pop and refill can overlap.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op  = grant1 ? req1_op : req0_op;
    assign illegal = (grant0 | grant1) & (sel_op > OP_MAX);

    // The ALU has no default case, so idle and illegal cycles present a harmless add 0,0.
    always_comb begin
        alu_op = OP_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (grant0 && !illegal) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (grant1 && !illegal) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
        end else if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= illegal ? '0 : alu_out;
            rsp0_zero   <= illegal ? 1'b1 : alu_zero;
            rsp0_err    <= illegal;
        end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_err    <= 1'b0;
        end else if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= illegal ? '0 : alu_out;
            rsp1_zero   <= illegal ? 1'b1 : alu_zero;
            rsp1_err    <= illegal;
        end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed vector bench for alu_share_arb with a reference ALU
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32), .OPW(4), .MAXOP(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return {31'd0, a < b};
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out  = alu_model(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_out == 32'd0);

    typedef struct {
        logic        v0, r0, v1, r1;
        logic [3:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic        erdy0, erdy1;
        logic [3:0]  eop;
        logic [31:0] ea, eb;
        logic        erv0, ez0, eerr0, erv1, ez1, eerr1;
        logic [31:0] eres0, eres1;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic r0,
        input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic r1,
        input logic erdy0, input logic erdy1, input logic [3:0] eop, input logic [31:0] ea, input logic [31:0] eb,
        input logic erv0, input logic [31:0] eres0, input logic ez0, input logic eerr0,
        input logic erv1, input logic [31:0] eres1, input logic ez1, input logic eerr1);
        vec_t t;
        t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.r0 = r0;
        t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1; t.r1 = r1;
        t.erdy0 = erdy0; t.erdy1 = erdy1; t.eop = eop; t.ea = ea; t.eb = eb;
        t.erv0 = erv0; t.eres0 = eres0; t.ez0 = ez0; t.eerr0 = eerr0;
        t.erv1 = erv1; t.eres1 = eres1; t.ez1 = ez1; t.eerr1 = eerr1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        req0_valid = t.v0; req0_op = t.op0; req0_a = t.a0; req0_b = t.b0; rsp0_ready = t.r0;
        req1_valid = t.v1; req1_op = t.op1; req1_a = t.a1; req1_b = t.b1; rsp1_ready = t.r1;
    endtask

    vec_t vecs[$];
    vec_t t;

    initial begin
        // idle, single op, pop + port1 xor
        vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 2,0,0, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,2,5,7,1, 0,0,0,0,1, 1,0, 2,5,7, 1,12,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,3,6,6,1, 0,1, 3,6,6, 0,12,0,0, 1,0,1,0));
        // contention: grants alternate 0,1,0,1
        vecs.push_back(mk(1,6,9,9,1, 1,8,32'hFFFFFFFF,1,1, 1,0, 6,9,9, 1,0,1,0, 0,0,1,0));
        vecs.push_back(mk(1,6,9,9,1, 1,8,32'hFFFFFFFF,1,1, 0,1, 8,32'hFFFFFFFF,1, 0,0,1,0, 1,1,0,0));
        vecs.push_back(mk(1,6,9,9,1, 1,8,32'hFFFFFFFF,1,1, 1,0, 6,9,9, 1,0,1,0, 0,1,0,0));
        vecs.push_back(mk(1,6,9,9,1, 1,8,32'hFFFFFFFF,1,1, 0,1, 8,32'hFFFFFFFF,1, 0,0,1,0, 1,1,0,0));
        // backpressure on port 0, port 1 streams, then port 0 regranted
        vecs.push_back(mk(1,2,5,7,1, 1,0,32'hFFFF0000,32'h0FF00FF0,1, 1,0, 2,5,7, 1,12,0,0, 0,1,0,0));
        vecs.push_back(mk(1,2,5,7,0, 1,1,32'h0F,32'hF0,1, 0,1, 1,32'h0F,32'hF0, 1,12,0,0, 1,32'hFF,0,0));
        vecs.push_back(mk(1,2,5,7,0, 1,4,1,4,1, 0,1, 4,1,4, 1,12,0,0, 1,16,0,0));
        vecs.push_back(mk(1,2,5,7,1, 1,5,32'h80,3,1, 1,0, 2,5,7, 1,12,0,0, 0,16,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,5,32'h80,3,1, 0,1, 5,32'h80,3, 0,12,0,0, 1,16,0,0));
        // illegal opcode, legal op 9 clears err, op 10 illegal, idle holds
        vecs.push_back(mk(0,0,0,0,1, 1,4'hC,3,4,1, 0,1, 2,0,0, 0,12,0,0, 1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1, 1,9,32'h80000000,4,1, 0,1, 9,32'h80000000,4, 0,12,0,0, 1,32'hF8000000,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,4'hA,1,1,1, 0,1, 2,0,0, 0,12,0,0, 1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 2,0,0, 0,12,0,0, 0,0,1,1));

        rst_n = 1'b0;
        drive(vecs[0]);
        #1;
        chk("reset_rsp0", {rsp0_valid, rsp0_result, rsp0_zero, rsp0_err}, 64'd0);
        chk("reset_rsp1", {rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            if (i != 0) @(negedge clk);
            drive(t);
            #1;
            chk($sformatf("v%0d_ready", i), {req0_ready, req1_ready}, {t.erdy0, t.erdy1});
            chk($sformatf("v%0d_alu", i), {alu_op, alu_a, alu_b}, {t.eop, t.ea, t.eb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp0", i), {rsp0_valid, rsp0_result, rsp0_zero, rsp0_err}, {t.erv0, t.eres0, t.ez0, t.eerr0});
            chk($sformatf("v%0d_rsp1", i), {rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, {t.erv1, t.eres1, t.ez1, t.eerr1});
        end

        // mid-operation reset: port 0 wins (last_grant becomes 0), then reset must restore port 0 priority
        @(negedge clk);
        t = mk(1,2,1,1,1, 1,2,2,2,1, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0);
        drive(t);
        #1;
        chk("mr_grant_pre", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        chk("mr_rsp0_pre", {rsp0_valid, rsp0_result}, {1'b1, 32'd2});
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rsp0_async", {rsp0_valid, rsp0_result, rsp0_zero, rsp0_err}, 64'd0);
        chk("mr_rsp1_async", {rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, 64'd0);
        @(posedge clk);
        #1;
        chk("mr_rsp_held", {rsp0_valid, rsp1_valid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("mr_first_contest", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        chk("mr_rsp0_post", {rsp0_valid, rsp0_result, rsp0_zero}, {1'b1, 32'd2, 1'b0});
        chk("mr_rsp1_post", {31'd0, rsp1_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
